// File: rtl/uart_cmd_pkg.sv
// Shared types and helpers for the UART command controller.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CSUM,
    ISSUE,
    WAIT_RSP,
    TX_LOAD,
    TX_WAIT
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Bits needed to hold a payload length in 0..max_len.
  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/uart_cmd_buf.sv
// Payload buffer: DEPTH x 8 register file, synchronous write, combinational read.
module uart_cmd_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Storage write; contents are not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Packet controller: receives framed commands, streams payload to the core,
// forwards response bytes to uart_tx.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 16,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       i_Clock,
  input  logic       reset,
  output logic       o_Rx_Enable,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Tx_En,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Active,
  input  logic       i_Tx_Done,
  output logic       o_Cmd_Valid,
  output logic [7:0] o_Cmd_Byte,
  output logic       o_Cmd_Last,
  input  logic       i_Cmd_Ready,
  input  logic       i_Rsp_Valid,
  input  logic [7:0] i_Rsp_Byte,
  input  logic       i_Rsp_Last,
  output logic       o_Rsp_Ready,
  output logic       o_Err_Pulse,
  output logic [1:0] o_Err_Code
);

  localparam int unsigned LW = len_width(MAX_LEN);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e        state, state_nx;
  logic [LW-1:0] len, wptr, rptr;
  logic [7:0]    sum, csum_nx, rdata;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit, rx_phase;
  logic          rsp_last, tx_pend;
  logic          buf_we, len_ld, rptr_inc, rsp_cap, tx_fire, err_set;
  err_e          err_val;

  uart_cmd_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk   (i_Clock),
    .we    (buf_we),
    .waddr (wptr[AW-1:0]),
    .wdata (i_Rx_Byte),
    .raddr (rptr[AW-1:0]),
    .rdata (rdata)
  );

  assign rx_phase = (state == LEN) || (state == PAYLOAD) || (state == CSUM);
  assign tmo_hit  = rx_phase && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign csum_nx  = sum + i_Rx_Byte;

  // State register.
  always_ff @(posedge i_Clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state, datapath strobes and combinational outputs.
  // A received byte takes priority over a coincident timeout.
  always_comb begin
    state_nx    = state;
    buf_we      = 1'b0;
    len_ld      = 1'b0;
    rptr_inc    = 1'b0;
    rsp_cap     = 1'b0;
    tx_fire     = 1'b0;
    err_set     = 1'b0;
    err_val     = ERR_NONE;
    o_Rx_Enable = 1'b0;
    o_Cmd_Valid = 1'b0;
    o_Cmd_Byte  = '0;
    o_Cmd_Last  = 1'b0;
    o_Rsp_Ready = 1'b0;
    case (state)
      IDLE: begin
        o_Rx_Enable = 1'b1;
        if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) state_nx = LEN;
      end
      LEN: begin
        o_Rx_Enable = 1'b1;
        if (i_Rx_DV) begin
          if (i_Rx_Byte == 8'd0 || {24'd0, i_Rx_Byte} > MAX_LEN) begin
            err_set  = 1'b1;
            err_val  = ERR_LEN;
            state_nx = IDLE;
          end else begin
            len_ld   = 1'b1;
            state_nx = PAYLOAD;
          end
        end else if (tmo_hit) begin
          err_set  = 1'b1;
          err_val  = ERR_TIMEOUT;
          state_nx = IDLE;
        end
      end
      PAYLOAD: begin
        o_Rx_Enable = 1'b1;
        if (i_Rx_DV) begin
          buf_we = 1'b1;
          if (wptr == len - LW'(1)) state_nx = CSUM;
        end else if (tmo_hit) begin
          err_set  = 1'b1;
          err_val  = ERR_TIMEOUT;
          state_nx = IDLE;
        end
      end
      CSUM: begin
        o_Rx_Enable = 1'b1;
        if (i_Rx_DV) begin
          if (csum_nx == 8'h00) begin
            state_nx = ISSUE;
          end else begin
            err_set  = 1'b1;
            err_val  = ERR_CSUM;
            state_nx = IDLE;
          end
        end else if (tmo_hit) begin
          err_set  = 1'b1;
          err_val  = ERR_TIMEOUT;
          state_nx = IDLE;
        end
      end
      ISSUE: begin
        o_Cmd_Valid = 1'b1;
        o_Cmd_Byte  = rdata;
        o_Cmd_Last  = (rptr == len - LW'(1));
        if (i_Cmd_Ready) begin
          rptr_inc = 1'b1;
          if (o_Cmd_Last) state_nx = WAIT_RSP;
        end
      end
      WAIT_RSP: state_nx = TX_LOAD;
      TX_LOAD: begin
        o_Rsp_Ready = 1'b1;
        if (i_Rsp_Valid) begin
          rsp_cap  = 1'b1;
          state_nx = TX_WAIT;
        end
      end
      TX_WAIT: begin
        // Start is held back while uart_tx is busy; completion counts only
        // after the start pulse has actually gone out.
        if (tx_pend) begin
          if (!i_Tx_Active) tx_fire = 1'b1;
        end else if (!o_Tx_En && i_Tx_Done) begin
          state_nx = rsp_last ? IDLE : TX_LOAD;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Inter-byte timeout: cleared on any byte, state change, or outside receive.
  always_ff @(posedge i_Clock or negedge reset) begin
    if (!reset)                                        tmo_cnt <= '0;
    else if (!rx_phase || i_Rx_DV || state_nx != state) tmo_cnt <= '0;
    else                                               tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Frame length, pointers and running checksum.
  always_ff @(posedge i_Clock or negedge reset) begin
    if (!reset) begin
      len  <= '0;
      wptr <= '0;
      rptr <= '0;
      sum  <= '0;
    end else begin
      if (len_ld) begin
        len  <= i_Rx_Byte[LW-1:0];
        sum  <= i_Rx_Byte;
        wptr <= '0;
        rptr <= '0;
      end
      if (buf_we) begin
        wptr <= wptr + 1'b1;
        sum  <= csum_nx;
      end
      if (rptr_inc) rptr <= rptr + 1'b1;
    end
  end

  // Response capture and uart_tx start pulse.
  always_ff @(posedge i_Clock or negedge reset) begin
    if (!reset) begin
      o_Tx_Byte <= '0;
      o_Tx_En   <= 1'b0;
      rsp_last  <= 1'b0;
      tx_pend   <= 1'b0;
    end else begin
      o_Tx_En <= tx_fire;
      if (rsp_cap) begin
        o_Tx_Byte <= i_Rsp_Byte;
        rsp_last  <= i_Rsp_Last;
        tx_pend   <= 1'b1;
      end else if (tx_fire) begin
        tx_pend <= 1'b0;
      end
    end
  end

  // Error pulse and sticky error code.
  always_ff @(posedge i_Clock or negedge reset) begin
    if (!reset) begin
      o_Err_Pulse <= 1'b0;
      o_Err_Code  <= '0;
    end else begin
      o_Err_Pulse <= err_set;
      if (err_set) o_Err_Code <= err_val;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a behavioural uart_tx responder.
module tb_uart_cmd_ctrl;

  localparam int unsigned TMO = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       o_Rx_Enable;
  logic       i_Rx_DV = 1'b0;
  logic [7:0] i_Rx_Byte = '0;
  logic       o_Tx_En;
  logic [7:0] o_Tx_Byte;
  logic       i_Tx_Active;
  logic       i_Tx_Done = 1'b0;
  logic       o_Cmd_Valid;
  logic [7:0] o_Cmd_Byte;
  logic       o_Cmd_Last;
  logic       i_Cmd_Ready;
  logic       i_Rsp_Valid = 1'b0;
  logic [7:0] i_Rsp_Byte = '0;
  logic       i_Rsp_Last = 1'b0;
  logic       o_Rsp_Ready;
  logic       o_Err_Pulse;
  logic [1:0] o_Err_Code;

  logic tx_busy = 1'b0, hold_active = 1'b0;
  logic ready_level = 1'b1, ready_toggle = 1'b0, tog = 1'b0;
  int   tx_cd = 0, tx_pulses = 0;
  int   n_checks = 0, n_errors = 0;

  logic [8:0] cmd_q[$];
  logic [1:0] err_q[$];
  logic [7:0] tx_q[$];
  logic       prev_stall = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_byte = '0;

  assign i_Tx_Active = tx_busy | hold_active;
  assign i_Cmd_Ready = ready_toggle ? tog : ready_level;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(.MAX_LEN(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
    .i_Clock(clk), .reset(reset),
    .o_Rx_Enable(o_Rx_Enable), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
    .o_Tx_En(o_Tx_En), .o_Tx_Byte(o_Tx_Byte), .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done),
    .o_Cmd_Valid(o_Cmd_Valid), .o_Cmd_Byte(o_Cmd_Byte), .o_Cmd_Last(o_Cmd_Last), .i_Cmd_Ready(i_Cmd_Ready),
    .i_Rsp_Valid(i_Rsp_Valid), .i_Rsp_Byte(i_Rsp_Byte), .i_Rsp_Last(i_Rsp_Last), .o_Rsp_Ready(o_Rsp_Ready),
    .o_Err_Pulse(o_Err_Pulse), .o_Err_Code(o_Err_Code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) tog <= ~tog;

  // Monitors: payload handshakes, hold-while-stalled, error pulses.
  always @(negedge clk) begin
    if (reset) begin
      if (prev_stall && o_Cmd_Valid) begin
        check("cmd_hold_byte", o_Cmd_Byte, prev_byte);
        check("cmd_hold_last", o_Cmd_Last, prev_last);
      end
      if (o_Cmd_Valid && i_Cmd_Ready) cmd_q.push_back({o_Cmd_Last, o_Cmd_Byte});
      prev_stall = o_Cmd_Valid && !i_Cmd_Ready;
      prev_byte  = o_Cmd_Byte;
      prev_last  = o_Cmd_Last;
      if (o_Err_Pulse) err_q.push_back(o_Err_Code);
    end else begin
      prev_stall = 1'b0;
    end
  end

  // uart_tx model: busy for a few cycles after each start, then a done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      tx_busy   = 1'b0;
      tx_cd     = 0;
      i_Tx_Done = 1'b0;
    end else begin
      i_Tx_Done = 1'b0;
      if (o_Tx_En) begin
        check("tx_en_when_idle", tx_busy, 1'b0);
        tx_q.push_back(o_Tx_Byte);
        tx_pulses++;
        tx_busy = 1'b1;
        tx_cd   = 6;
      end else if (tx_busy) begin
        if (tx_cd == 0) begin
          tx_busy   = 1'b0;
          i_Tx_Done = 1'b1;
        end else begin
          tx_cd--;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    tick();
    i_Rx_DV   = 1'b0;
    tick();
  endtask

  task automatic send_rsp(input logic [7:0] b, input logic last);
    i_Rsp_Valid = 1'b1;
    i_Rsp_Byte  = b;
    i_Rsp_Last  = last;
    for (int i = 0; i < 300 && !o_Rsp_Ready; i++) tick();
    check("rsp_ready_seen", o_Rsp_Ready, 1'b1);
    tick();
    i_Rsp_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && !o_Rx_Enable; i++) tick();
    check("idle_reached", o_Rx_Enable, 1'b1);
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 300 && tx_pulses < n; i++) tick();
    check("tx_pulse_seen", (tx_pulses >= n), 1'b1);
  endtask

  task automatic clear_logs();
    cmd_q.delete();
    err_q.delete();
    tx_q.delete();
    tx_pulses = 0;
  endtask

  task automatic finish_cmd_single_rsp(input logic [7:0] b);
    send_rsp(b, 1'b1);
    wait_idle();
  endtask

  initial begin
    // Reset values while reset is asserted.
    tick(3);
    check("rst_rx_en", o_Rx_Enable, 1'b1);
    check("rst_tx_en", o_Tx_En, 1'b0);
    check("rst_tx_byte", o_Tx_Byte, 8'h00);
    check("rst_cmd_valid", o_Cmd_Valid, 1'b0);
    check("rst_rsp_ready", o_Rsp_Ready, 1'b0);
    check("rst_err", {o_Err_Pulse, o_Err_Code}, 3'b000);
    reset = 1'b1;
    tick(2);

    // Good 2-byte frame.
    clear_logs();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h61); send_byte(8'h62); send_byte(8'h3B);
    tick(5);
    check("f1_cmd_count", cmd_q.size(), 2);
    check("f1_cmd0", (cmd_q.size() > 0) ? cmd_q[0] : 9'h1FF, 9'h061);
    check("f1_cmd1", (cmd_q.size() > 1) ? cmd_q[1] : 9'h1FF, 9'h162);
    check("f1_rx_en_off", o_Rx_Enable, 1'b0);
    finish_cmd_single_rsp(8'h55);
    check("f1_tx_byte", (tx_q.size() > 0) ? tx_q[0] : 8'hEE, 8'h55);
    check("f1_no_err", err_q.size(), 0);

    // Noise before sync is ignored.
    clear_logs();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
    tick(4);
    check("f2_cmd_count", cmd_q.size(), 1);
    check("f2_cmd0", (cmd_q.size() > 0) ? cmd_q[0] : 9'h1FF, 9'h17F);
    finish_cmd_single_rsp(8'h66);
    check("f2_no_err", err_q.size(), 0);

    // Bad checksum.
    clear_logs();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h61); send_byte(8'h00);
    tick(4);
    check("csum_err_count", err_q.size(), 1);
    check("csum_err_code", (err_q.size() > 0) ? err_q[0] : 2'bxx, 2'd2);
    check("csum_err_sticky", o_Err_Code, 2'd2);
    check("csum_no_cmd", cmd_q.size(), 0);
    check("csum_rx_en", o_Rx_Enable, 1'b1);

    // Bad lengths 0 and MAX_LEN+1.
    clear_logs();
    send_byte(8'hA5); send_byte(8'h00);
    send_byte(8'hA5); send_byte(8'h11);
    tick(3);
    check("len_err_count", err_q.size(), 2);
    check("len_err0", (err_q.size() > 0) ? err_q[0] : 2'bxx, 2'd1);
    check("len_err1", (err_q.size() > 1) ? err_q[1] : 2'bxx, 2'd1);

    // Inter-byte timeout mid-payload.
    clear_logs();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01);
    tick(150);
    check("tmo_not_early", err_q.size(), 0);
    tick(70);
    check("tmo_err_count", err_q.size(), 1);
    check("tmo_err_code", (err_q.size() > 0) ? err_q[0] : 2'bxx, 2'd3);
    check("tmo_idle", o_Rx_Enable, 1'b1);
    check("tmo_no_cmd", cmd_q.size(), 0);

    // 3-byte command with stalls, then 3-byte response with a busy uart_tx.
    clear_logs();
    ready_toggle = 1'b1;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h97);
    tick(12);
    ready_toggle = 1'b0;
    check("stall_cmd_count", cmd_q.size(), 3);
    check("stall_cmd0", (cmd_q.size() > 0) ? cmd_q[0] : 9'h1FF, 9'h011);
    check("stall_cmd1", (cmd_q.size() > 1) ? cmd_q[1] : 9'h1FF, 9'h022);
    check("stall_cmd2", (cmd_q.size() > 2) ? cmd_q[2] : 9'h1FF, 9'h133);
    hold_active = 1'b1;
    send_rsp(8'h10, 1'b0);
    tick(20);
    check("tx_deferred", tx_pulses, 0);
    hold_active = 1'b0;
    wait_tx(1);
    send_rsp(8'h20, 1'b0);
    send_rsp(8'h30, 1'b1);
    wait_idle();
    check("rsp_pulses", tx_pulses, 3);
    check("rsp_b0", (tx_q.size() > 0) ? tx_q[0] : 8'hEE, 8'h10);
    check("rsp_b1", (tx_q.size() > 1) ? tx_q[1] : 8'hEE, 8'h20);
    check("rsp_b2", (tx_q.size() > 2) ? tx_q[2] : 8'hEE, 8'h30);

    // Asynchronous reset during the second response byte.
    clear_logs();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
    send_rsp(8'h10, 1'b0);
    send_rsp(8'h20, 1'b0);
    wait_tx(2);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_rx_en", o_Rx_Enable, 1'b1);
    check("arst_tx_en", o_Tx_En, 1'b0);
    check("arst_tx_byte", o_Tx_Byte, 8'h00);
    check("arst_rsp_ready", o_Rsp_Ready, 1'b0);
    check("arst_cmd", {o_Cmd_Valid, o_Cmd_Last, o_Cmd_Byte}, 10'd0);
    check("arst_err", {o_Err_Pulse, o_Err_Code}, 3'b000);
    tick(2);
    reset = 1'b1;
    tick(2);
    clear_logs();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h61); send_byte(8'h62); send_byte(8'h3B);
    tick(5);
    check("post_rst_cmd_count", cmd_q.size(), 2);
    check("post_rst_cmd1", (cmd_q.size() > 1) ? cmd_q[1] : 9'h1FF, 9'h162);
    finish_cmd_single_rsp(8'h77);
    check("post_rst_tx", (tx_q.size() > 0) ? tx_q[0] : 8'hEE, 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Packet-level controller that sequences the uart_rx/uart_tx pair for the accelerator. It enables reception and parses framed command packets (sync, length, payload, checksum) into an internal buffer. It streams each validated payload to the accelerator core, then forwards the core's response bytes one at a time through uart_tx. It sits between the UART primitives and the accelerator top.

Parameters:
MAX_LEN, 16, maximum payload bytes per command (1..MAX_LEN legal)
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 100000, maximum i_Clock cycles between received bytes inside a frame

Ports:
i_Clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
o_Rx_Enable  out  1  drives uart_rx receive enable
i_Rx_DV  in  1  uart_rx byte-valid, one-cycle pulse
i_Rx_Byte  in  8  uart_rx byte
o_Tx_En  out  1  uart_tx start, one-cycle pulse
o_Tx_Byte  out  8  uart_tx data, held until i_Tx_Done
i_Tx_Active  in  1  uart_tx busy
i_Tx_Done  in  1  uart_tx byte-complete pulse
o_Cmd_Valid  out  1  payload byte valid to core
o_Cmd_Byte  out  8  payload byte
o_Cmd_Last  out  1  final payload byte
i_Cmd_Ready  in  1  core accepts payload byte
i_Rsp_Valid  in  1  core response byte valid
i_Rsp_Byte  in  8  response byte
i_Rsp_Last  in  1  final response byte
o_Rsp_Ready  out  1  controller accepts response byte
o_Err_Pulse  out  1  one-cycle frame-error pulse
o_Err_Code  out  2  1=bad length, 2=bad checksum, 3=timeout; held until next error

Behaviour:
- Reset (reset low, asynchronous): state IDLE. All outputs 0 except o_Rx_Enable=1. Buffer pointers, checksum and timeout counter cleared.
- FSM states: IDLE, LEN, PAYLOAD, CSUM, ISSUE, WAIT_RSP, TX_LOAD, TX_WAIT.
- IDLE: on i_Rx_DV with byte==SYNC_BYTE go to LEN. All other bytes are ignored silently.
- LEN: byte 0 or >MAX_LEN raises error 1 and returns to IDLE. Otherwise latch len, set sum=len, and go to PAYLOAD.
- PAYLOAD: write byte to buffer[wptr], increment wptr, sum+=byte (mod 256). After len bytes go to CSUM.
- CSUM: if (sum+byte) mod 256 == 0, go to ISSUE. Otherwise raise error 2 and go to IDLE.
- Timeout: the counter clears on every i_Rx_DV and on state entry, and runs only in LEN/PAYLOAD/CSUM. When it reaches TIMEOUT_CYCLES-1, raise error 3 and go to IDLE. Partial payload is discarded.
- o_Rx_Enable=1 only in IDLE/LEN/PAYLOAD/CSUM. i_Rx_DV in any other state is ignored.
- ISSUE: o_Cmd_Valid=1, o_Cmd_Byte=buffer[rptr], o_Cmd_Last=(rptr==len-1).
  - Transfer occurs on Valid&&Ready; rptr then increments.
  - Byte and Last are held stable while Ready is low.
  - After the last transfer, go to WAIT_RSP.
- WAIT_RSP/TX_LOAD: o_Rsp_Ready=1 only in TX_LOAD, which is entered from WAIT_RSP immediately.
  - On Valid&&Ready, capture byte and last flag, pulse o_Tx_En for exactly one cycle, and go to TX_WAIT.
- TX_WAIT: o_Rsp_Ready=0. On i_Tx_Done, go to IDLE if the captured last flag is set, else to TX_LOAD.
  - i_Tx_Active is checked before pulsing o_Tx_En. If busy, the pulse is deferred until it is low.
- Response length is unbounded. A response is accepted only after the full command has issued.
- Error pulse: o_Err_Pulse high one cycle, coincident with o_Err_Code update.
- Simultaneous timeout and i_Rx_DV in the same cycle: the byte wins, and the counter clears.
- Reset mid-transfer: any in-flight uart_tx byte is abandoned. After reset the controller is in IDLE with o_Tx_En=0.
- Back-to-back frames: a SYNC_BYTE arriving in the same cycle IDLE is re-entered from an error is not captured. The frame must be resent.

Decomposition:
- uart_cmd_pkg: state encoding, error code constants (ERR_LEN, ERR_CSUM, ERR_TIMEOUT), SYNC_BYTE default, and a len width helper of $clog2(MAX_LEN+1).
- One sub-module: uart_cmd_buf, a MAX_LEN x 8 register file.
  - Synchronous write port (we, waddr, wdata) and combinational read port (raddr, rdata).
  - No reset on storage.

Test Plan:
- Frame A5 02 61 62 3B via uart_tx loopback, i_Cmd_Ready=1 -> o_Cmd_Byte 61 then 62 (Last on 62), no error.
- Bytes 00 FF 13 then A5 01 7F 80 -> noise ignored; single Cmd byte 7F with Last=1.
- A5 01 61 00 -> o_Err_Pulse once with code 2; no o_Cmd_Valid; o_Rx_Enable stays 1.
- A5 00 and A5 11 (MAX_LEN=16) -> error code 1 each.
- A5 03 01, then idle for TIMEOUT_CYCLES -> error code 3, state IDLE.
- Cmd with i_Cmd_Ready toggled 1/0, then a 3-byte response 10 20 30 (Last on 30) -> Cmd bytes held stable while Ready is low.
  - Exactly 3 o_Tx_En pulses, each after the prior i_Tx_Done; uart_rx loopback decodes 10 20 30.
- Assert reset during the second response byte -> all outputs at reset values within the same cycle (async); the next frame processes normally.
